// File: rtl/plane_calc_sched_pkg.sv
// Shared types and default sizing for the plane surface-calculation scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_CALC,
    PUSH,
    DONE
  } sched_state_t;

  localparam int PLANES_DEF  = 64;
  localparam int SAMPLES_DEF = 8;
  localparam int ADDR_W_DEF  = 9;
  localparam int SURF_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/plane_calc_sched_if.sv
// Calculator-side address stream plus the per-plane result handshake.
interface plane_calc_sched_if #(
  parameter int ADDR_W  = 9,
  parameter int PLANE_W = 6,
  parameter int SURF_W  = 32
) ();

  logic [ADDR_W-1:0]  bram_addr;
  logic               calc_en;
  logic               calc_rdy;
  logic [SURF_W-1:0]  calc_surf;
  logic               res_valid;
  logic               res_ready;
  logic [PLANE_W-1:0] res_plane;
  logic [SURF_W-1:0]  res_surf;

  // master = scheduler, slave = calculator + downstream result consumer
  modport master (
    output bram_addr, calc_en, res_valid, res_plane, res_surf,
    input  calc_rdy, calc_surf, res_ready
  );

  modport slave (
    input  bram_addr, calc_en, res_valid, res_plane, res_surf,
    output calc_rdy, calc_surf, res_ready
  );

endinterface

// File: rtl/plane_calc_sched_watchdog.sv
// Cycle watchdog for the wait-on-calculator state; expires on its TIMEOUT-th running cycle.
module calc_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/plane_calc_sched.sv
// Frame scheduler: on a drdy rising edge, walks every plane's BRAM samples through the
// surface calculator, forwards one result per plane and accumulates the frame total.
module plane_calc_sched
  import sched_pkg::*;
#(
  parameter int PLANES  = PLANES_DEF,
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SURF_W  = SURF_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int PLANE_W = $clog2(PLANES),
  localparam int K_W     = $clog2(SAMPLES),
  localparam int ACC_W   = SURF_W + PLANE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 drdy,
  plane_calc_sched_if.master   bus,
  output logic [ACC_W-1:0]     frame_surf,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  sched_state_t       state;
  logic               drdy_q;
  logic [PLANE_W-1:0] plane;
  logic [K_W-1:0]     k;
  logic [ACC_W-1:0]   acc;
  logic               wd_expired;

  wire drdy_rise  = drdy & ~drdy_q;
  wire last_plane = (plane == PLANE_W'(PLANES - 1));
  wire last_k     = (k == K_W'(SAMPLES - 1));

  assign busy       = (state != IDLE);
  assign frame_surf = acc;

  calc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != WAIT_CALC),
    .run     (state == WAIT_CALC),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      // drdy_q resets high so a level already present at reset release is not a start.
      drdy_q        <= 1'b1;
      plane         <= '0;
      k             <= '0;
      acc           <= '0;
      bus.bram_addr <= '0;
      bus.calc_en   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_plane <= '0;
      bus.res_surf  <= '0;
      frame_done    <= 1'b0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      drdy_q     <= drdy;
      frame_done <= 1'b0;

      // Edges outside IDLE (including DONE) are flagged and dropped, never queued.
      if (drdy_rise && state != IDLE) err_overrun <= 1'b1;

      unique case (state)
        IDLE: begin
          if (drdy_rise) begin
            plane         <= '0;
            k             <= '0;
            acc           <= '0;
            err_timeout   <= 1'b0;
            err_overrun   <= 1'b0;
            bus.bram_addr <= '0;
            bus.calc_en   <= 1'b1;
            state         <= ADDR;
          end
        end

        ADDR: begin
          if (last_k) begin
            state <= WAIT_CALC;
          end else begin
            k             <= k + K_W'(1);
            bus.bram_addr <= bus.bram_addr + ADDR_W'(1);
          end
        end

        WAIT_CALC: begin
          // A result arriving on the expiry cycle still counts.
          if (bus.calc_rdy) begin
            bus.res_surf  <= bus.calc_surf;
            bus.res_plane <= plane;
            bus.res_valid <= 1'b1;
            bus.calc_en   <= 1'b0;
            acc           <= acc + ACC_W'(bus.calc_surf);
            state         <= PUSH;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            bus.calc_en <= 1'b0;
            frame_done  <= 1'b1;
            state       <= DONE;
          end
        end

        PUSH: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (last_plane) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              // Planes are contiguous, so the next plane's base is last address + 1.
              plane         <= plane + PLANE_W'(1);
              k             <= '0;
              bus.bram_addr <= bus.bram_addr + ADDR_W'(1);
              bus.calc_en   <= 1'b1;
              state         <= ADDR;
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
